// File: rtl/delay_tdc_pkg.sv
// -----------------------------------------------------------------------------
// delay_tdc_pkg
// Shared types and helpers for the delay-tap capture block.
//   state_t : sequencing states of the launch/capture controller
//   clog2   : elaboration-time ceiling log2, used to size the tap-count output
//             and the settle counter
// -----------------------------------------------------------------------------
package delay_tdc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        SAMPLE = 3'd2,
        DECODE = 3'd3,
        HOLD   = 3'd4,
        DRAIN  = 3'd5
    } state_t;

    // Ceiling log2 with a floor of 1 so that a counter that only has to
    // hold 0 or 1 still gets a real bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/thermo_decode.sv
// -----------------------------------------------------------------------------
// thermo_decode
// Combinational decode of a captured delay-chain snapshot.
//   code   in   TAPS   captured taps, bit 0 nearest the launch point
//   count  out  CNT_W  number of consecutive ones starting at bit 0 (0..TAPS)
//   bubble out  1      a one exists above the first zero (not a clean thermometer)
//   full   out  1      every tap was one; count then equals TAPS
// Bubbles are reported alongside the raw leading-ones count; no correction is
// attempted, so the consumer can decide how to treat a noisy snapshot.
// -----------------------------------------------------------------------------
module thermo_decode
    import delay_tdc_pkg::*;
#(
    parameter  int TAPS  = 16,
    localparam int CNT_W = clog2(TAPS + 1)
) (
    input  logic [TAPS-1:0]  code,
    output logic [CNT_W-1:0] count,
    output logic             bubble,
    output logic             full
);

    logic found_zero;

    always_comb begin
        count      = CNT_W'(TAPS);
        bubble     = 1'b0;
        found_zero = 1'b0;
        for (int i = 0; i < TAPS; i++) begin
            if (!code[i]) begin
                if (!found_zero) begin
                    found_zero = 1'b1;
                    count      = CNT_W'(i);
                end
            end else if (found_zero) begin
                bubble = 1'b1;
            end
        end
        full = ~found_zero;
    end

endmodule

// File: rtl/delay_tap_capture.sv
// -----------------------------------------------------------------------------
// delay_tap_capture
// Launches a rising edge into an external delayed_and chain, samples the chain
// taps a fixed number of clocks later, decodes the thermometer code and hands
// the result over a valid/ready handshake. After the result is taken the
// launch edge is dropped and the chain is given time to drain before the next
// measurement may start.
//
// Ports
//   clk       in   1      single clock, rising edge
//   rst_n     in   1      asynchronous active-low reset
//   start_i   in   1      measurement request, only looked at while idle
//   launch_o  out  1      registered edge driven into the chain input
//   taps_i    in   TAPS   chain tap outputs (asynchronous to clk), tap0 nearest launch
//   busy_o    out  1      measurement in progress (launch through drain)
//   valid_o   out  1      result valid, held until ready_i
//   ready_i   in   1      consumer takes result on valid_o & ready_i
//   count_o   out  CNT_W  leading-ones count from tap0
//   bubble_o  out  1      snapshot was not a clean thermometer code
//   full_o    out  1      all taps were one (edge outran the chain)
//
// State table
//   state  | meaning
//   IDLE   | waiting for start_i, launch_o low, chain drained
//   LAUNCH | launch_o high, settle counter running; taps captured on terminal count
//   SAMPLE | second capture stage resolves metastability on the async taps
//   DECODE | decoded result registered onto the outputs, valid_o raised
//   HOLD   | result presented until the consumer accepts it; launch_o stays high
//   DRAIN  | launch_o low for SETTLE_CYCLES clocks so the chain returns to zero
// -----------------------------------------------------------------------------
module delay_tap_capture
    import delay_tdc_pkg::*;
#(
    parameter  int TAPS          = 16,
    parameter  int SETTLE_CYCLES = 4,
    localparam int CNT_W         = clog2(TAPS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    output logic             launch_o,
    input  logic [TAPS-1:0]  taps_i,
    output logic             busy_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [CNT_W-1:0] count_o,
    output logic             bubble_o,
    output logic             full_o
);

    localparam int              SET_W       = clog2(SETTLE_CYCLES + 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

    state_t            state;
    logic [SET_W-1:0]  settle_cnt;
    logic [TAPS-1:0]   cap1;
    logic [TAPS-1:0]   cap2;

    logic [CNT_W-1:0]  dec_count;
    logic              dec_bubble;
    logic              dec_full;

    thermo_decode #(
        .TAPS (TAPS)
    ) u_thermo_decode (
        .code   (cap2),
        .count  (dec_count),
        .bubble (dec_bubble),
        .full   (dec_full)
    );

    // Loading SETTLE_CYCLES-1 and leaving on the terminal-count edge gives
    // exactly SETTLE_CYCLES edges in LAUNCH (and in DRAIN) after the entry edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            cap1       <= '0;
            cap2       <= '0;
            launch_o   <= 1'b0;
            busy_o     <= 1'b0;
            valid_o    <= 1'b0;
            count_o    <= '0;
            bubble_o   <= 1'b0;
            full_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state      <= LAUNCH;
                        launch_o   <= 1'b1;
                        busy_o     <= 1'b1;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end

                LAUNCH: begin
                    if (settle_cnt == '0) begin
                        cap1  <= taps_i;
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                end

                SAMPLE: begin
                    cap2  <= cap1;
                    state <= DECODE;
                end

                DECODE: begin
                    count_o  <= dec_count;
                    bubble_o <= dec_bubble;
                    full_o   <= dec_full;
                    valid_o  <= 1'b1;
                    state    <= HOLD;
                end

                HOLD: begin
                    // valid_o is already high here, so the handshake is
                    // simply ready_i; the result is held at least one cycle.
                    if (ready_i) begin
                        valid_o    <= 1'b0;
                        launch_o   <= 1'b0;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= DRAIN;
                    end
                end

                DRAIN: begin
                    if (settle_cnt == '0) begin
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                end

                default: begin
                    state    <= IDLE;
                    launch_o <= 1'b0;
                    busy_o   <= 1'b0;
                    valid_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_delay_tap_capture.sv
module tb_delay_tap_capture;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic        launch_o;
    logic [15:0] taps_i;
    logic        busy_o;
    logic        valid_o;
    logic        ready_i;
    logic [4:0]  count_o;
    logic        bubble_o;
    logic        full_o;

    int n_checks;
    int n_fail;

    delay_tap_capture #(
        .TAPS          (16),
        .SETTLE_CYCLES (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .launch_o (launch_o),
        .taps_i   (taps_i),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .count_o  (count_o),
        .bubble_o (bubble_o),
        .full_o   (full_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({launch_o, busy_o, valid_o, bubble_o, full_o, count_o} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_async: outputs=%b expected 0", {launch_o, busy_o, valid_o, bubble_o, full_o, count_o});
        end
        tick();
        tick();
        n_checks++;
        if ({launch_o, busy_o, valid_o, bubble_o, full_o, count_o} !== 10'b0) begin
            n_fail++;
            $display("FAIL reset_clocked: outputs=%b expected 0", {launch_o, busy_o, valid_o, bubble_o, full_o, count_o});
        end
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({launch_o, busy_o, valid_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release_idle: launch/busy/valid=%b expected 000", {launch_o, busy_o, valid_o});
        end
    endtask

    // Start at E0, taps only correct in the window around the E4 capture edge.
    task automatic test_basic_timing();
        taps_i  = 16'h0000;
        start_i = 1'b1;
        tick();                       // E0
        start_i = 1'b0;
        n_checks++;
        if ({launch_o, busy_o, valid_o} !== 3'b110) begin
            n_fail++;
            $display("FAIL t1_after_e0: launch/busy/valid=%b expected 110", {launch_o, busy_o, valid_o});
        end
        for (int e = 1; e <= 5; e++) begin
            if (e == 4) taps_i = 16'h003F;   // present for edge E4 only
            tick();
            if (e == 4) taps_i = 16'hFFFF;   // later changes must not matter
            n_checks++;
            if (valid_o !== 1'b0 || launch_o !== 1'b1) begin
                n_fail++;
                $display("FAIL t1_pre_valid_e%0d: valid=%b launch=%b expected 0/1", e, valid_o, launch_o);
            end
        end
        tick();                       // E6
        n_checks++;
        if (valid_o !== 1'b1 || count_o !== 5'd6 || bubble_o !== 1'b0 || full_o !== 1'b0) begin
            n_fail++;
            $display("FAIL t1_result_e6: valid=%b count=%0d bubble=%b full=%b expected 1/6/0/0", valid_o, count_o, bubble_o, full_o);
        end
        tick();                       // E7
        ready_i = 1'b1;
        tick();                       // E8
        ready_i = 1'b0;
        n_checks++;
        if (valid_o !== 1'b0 || launch_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL t1_accept_e8: valid=%b launch=%b busy=%b expected 0/0/1", valid_o, launch_o, busy_o);
        end
        for (int e = 9; e <= 11; e++) begin
            tick();
            n_checks++;
            if (busy_o !== 1'b1 || launch_o !== 1'b0) begin
                n_fail++;
                $display("FAIL t1_drain_e%0d: busy=%b launch=%b expected 1/0", e, busy_o, launch_o);
            end
        end
        tick();                       // E12
        n_checks++;
        if (busy_o !== 1'b0 || count_o !== 5'd6) begin
            n_fail++;
            $display("FAIL t1_idle_e12: busy=%b count=%0d expected 0/6", busy_o, count_o);
        end
    endtask

    task automatic test_decode_patterns();
        logic [15:0] pat  [6];
        logic [4:0]  ecnt [6];
        logic        ebub [6];
        logic        eful [6];
        pat  = '{16'h00B7, 16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF, 16'h0001};
        ecnt = '{5'd3,     5'd16,    5'd0,     5'd0,     5'd15,    5'd1};
        ebub = '{1'b1,     1'b0,     1'b0,     1'b1,     1'b0,     1'b0};
        eful = '{1'b0,     1'b1,     1'b0,     1'b0,     1'b0,     1'b0};
        for (int k = 0; k < 6; k++) begin
            taps_i  = pat[k];
            start_i = 1'b1;
            tick();                   // E0
            start_i = 1'b0;
            repeat (6) tick();        // E6
            n_checks++;
            if (valid_o !== 1'b1 || count_o !== ecnt[k] || bubble_o !== ebub[k] || full_o !== eful[k]) begin
                n_fail++;
                $display("FAIL decode_%h: valid=%b count=%0d bubble=%b full=%b expected 1/%0d/%b/%b", pat[k], valid_o, count_o, bubble_o, full_o, ecnt[k], ebub[k], eful[k]);
            end
            ready_i = 1'b1;
            tick();
            ready_i = 1'b0;
            repeat (4) tick();
            n_checks++;
            if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
                n_fail++;
                $display("FAIL decode_%h_return: busy=%b valid=%b expected 0/0", pat[k], busy_o, valid_o);
            end
        end
    endtask

    task automatic test_hold_and_ignore_start();
        int bad;
        taps_i  = 16'h01FF;
        start_i = 1'b1;
        tick();                       // E0
        start_i = 1'b0;
        repeat (6) tick();            // E6, valid up
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            start_i = (c == 3 || c == 4);
            taps_i  = 16'h0000;
            tick();
            if (valid_o !== 1'b1 || count_o !== 5'd9 || launch_o !== 1'b1) bad++;
        end
        start_i = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL t4_hold_stable: %0d unstable cycles expected 0", bad);
        end
        ready_i = 1'b1;
        tick();                       // accept edge A
        ready_i = 1'b0;
        start_i = 1'b1;
        tick();                       // A+1
        tick();                       // A+2
        start_i = 1'b0;
        tick();                       // A+3
        tick();                       // A+4
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            if (busy_o !== 1'b0 || launch_o !== 1'b0 || valid_o !== 1'b0) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL t4_no_second_run: %0d busy cycles after drain expected 0", bad);
        end
    endtask

    task automatic test_reset_mid_run();
        int bad;
        taps_i  = 16'h000F;
        start_i = 1'b1;
        tick();                       // E0
        start_i = 1'b0;
        tick();                       // E1, in LAUNCH
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({launch_o, valid_o, busy_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL t5_reset_launch: launch/valid/busy=%b expected 000", {launch_o, valid_o, busy_o});
        end
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (valid_o !== 1'b0 || busy_o !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL t5_quiet_after_launch_reset: %0d active cycles expected 0", bad);
        end
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (6) tick();            // HOLD
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({launch_o, valid_o, busy_o, count_o} !== 8'b0) begin
            n_fail++;
            $display("FAIL t5_reset_hold: launch/valid/busy/count=%b expected 0", {launch_o, valid_o, busy_o, count_o});
        end
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (valid_o !== 1'b0 || busy_o !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL t5_quiet_after_hold_reset: %0d active cycles expected 0", bad);
        end
        taps_i  = 16'h0FFF;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (6) tick();
        n_checks++;
        if (valid_o !== 1'b1 || count_o !== 5'd12 || bubble_o !== 1'b0 || full_o !== 1'b0) begin
            n_fail++;
            $display("FAIL t5_fresh_run: valid=%b count=%0d bubble=%b full=%b expected 1/12/0/0", valid_o, count_o, bubble_o, full_o);
        end
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_back_to_back();
        int  npulse;
        int  last;
        logic prev;
        taps_i  = 16'h07FF;
        start_i = 1'b1;
        ready_i = 1'b1;
        tick();                       // E0
        npulse = 0;
        last   = 0;
        prev   = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (valid_o === 1'b1) begin
                n_checks++;
                if (prev === 1'b1) begin
                    n_fail++;
                    $display("FAIL t6_width: valid high two cycles at cycle %0d expected one", c);
                end
                n_checks++;
                if ((npulse == 0 && c != 6) || (npulse != 0 && c - last != 12) || count_o !== 5'd11) begin
                    n_fail++;
                    $display("FAIL t6_period: pulse at cycle %0d (prev %0d) count=%0d expected cycle 6+12n count 11", c, last, count_o);
                end
                last = c;
                npulse++;
            end
            prev = valid_o;
        end
        start_i = 1'b0;
        ready_i = 1'b0;
        n_checks++;
        if (npulse != 3) begin
            n_fail++;
            $display("FAIL t6_pulse_count: %0d pulses expected 3", npulse);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        start_i  = 1'b0;
        ready_i  = 1'b0;
        taps_i   = 16'h0000;
        test_reset();
        test_basic_timing();
        test_decode_patterns();
        test_hold_and_ignore_start();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
